// File: rtl/shape_span_raster_if.sv
// Request/pixel bundle between a shape producer and the span rasteriser.
interface shape_span_raster_if #(
    parameter int unsigned CORDW = 9
);
    logic             start;
    logic             oe;
    logic [1:0]       mode;
    logic [1:0]       orient;
    logic [CORDW-1:0] x0;
    logic [CORDW-1:0] y0;
    logic [CORDW-1:0] w;
    logic [CORDW-1:0] h;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             drawing;
    logic             busy;
    logic             done;

    modport master (
        output start, oe, mode, orient, x0, y0, w, h,
        input  x, y, drawing, busy, done
    );

    modport slave (
        input  start, oe, mode, orient, x0, y0, w, h,
        output x, y, drawing, busy, done
    );
endinterface

// File: rtl/shape_span_raster.sv
// Filled rect / right-isosceles triangle / parallelogram rasteriser, one pixel per enabled cycle.
// Optional clipping to CLIP_W x CLIP_H is enabled by defining RASTER_CLIP_EN.
module shape_span_raster #(
    parameter int unsigned CORDW = 9
`ifdef RASTER_CLIP_EN
    ,
    parameter int unsigned CLIP_W = 320,
    parameter int unsigned CLIP_H = 240
`endif
) (
    input  logic                clk,
    input  logic                rst,
    shape_span_raster_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StSpan, StDraw, StDone} state_e;

    localparam logic [1:0]       ModeTri  = 2'd1;
    localparam logic [1:0]       ModePara = 2'd2;
    localparam logic [1:0]       ModeRsvd = 2'd3;
    localparam logic [CORDW:0]   OneW     = {{CORDW{1'b0}}, 1'b1};
    localparam logic [CORDW-1:0] OneN     = {{(CORDW-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [1:0]       mode_q, orient_q;
    logic [CORDW-1:0] x0_q, w_q, h_q, rows_q;
    logic [CORDW-1:0] y_q, y_d, r_q, r_d;
    logic [CORDW:0]   x_q, x_d, t_q, t_d;

    logic             load, empty_in, last_row, vis;
    logic [CORDW-1:0] rows_in;
    logic [CORDW:0]   x0_e, w_e, h_e, r_e, span_s, span_t;

    assign rows_in  = (bus_io.mode == ModeTri) ? bus_io.w : bus_io.h;
    assign empty_in = (bus_io.mode == ModeRsvd) || (bus_io.w == '0) || (rows_in == '0);
    assign load     = (state_q == StIdle) && bus_io.start;
    assign last_row = (r_q == rows_q - OneN);

    assign x0_e = {1'b0, x0_q};
    assign w_e  = {1'b0, w_q};
    assign h_e  = {1'b0, h_q};
    assign r_e  = {1'b0, r_q};

    // Span of the current row, computed one bit wider than the coordinates.
    always_comb begin
        span_s = x0_e;
        span_t = x0_e + w_e - OneW;
        case (mode_q)
            ModeTri: begin
                unique case (orient_q)
                    2'd0: begin
                        span_s = x0_e;
                        span_t = x0_e + r_e;
                    end
                    2'd1: begin
                        span_s = x0_e + w_e - OneW - r_e;
                        span_t = x0_e + w_e - OneW;
                    end
                    2'd2: begin
                        span_s = x0_e;
                        span_t = x0_e + w_e - OneW - r_e;
                    end
                    2'd3: begin
                        span_s = x0_e + r_e;
                        span_t = x0_e + w_e - OneW;
                    end
                endcase
            end
            ModePara: begin
                span_s = orient_q[0] ? (x0_e + h_e - OneW - r_e) : (x0_e + r_e);
                span_t = span_s + w_e - OneW;
            end
            default: begin
                span_s = x0_e;
                span_t = x0_e + w_e - OneW;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        t_d     = t_q;
        y_d     = y_q;
        r_d     = r_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    y_d     = bus_io.y0;
                    r_d     = '0;
                    state_d = empty_in ? StDone : StSpan;
                end
            end
            StSpan: begin
                x_d     = span_s;
                t_d     = span_t;
                state_d = StDraw;
            end
            StDraw: begin
                if (bus_io.oe) begin
                    if (x_q == t_q) begin
                        if (last_row) begin
                            state_d = StDone;
                        end else begin
                            y_d     = y_q + OneN;
                            r_d     = r_q + OneN;
                            state_d = StSpan;
                        end
                    end else begin
                        x_d = x_q + OneW;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            t_q     <= t_d;
            y_q     <= y_d;
            r_q     <= r_d;
        end
    end

`ifdef RASTER_CLIP_EN
    logic [CORDW-1:0] y0_q;
    logic [CORDW:0]   y_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0_q <= '0;
        end else if (load) begin
            y0_q <= bus_io.y0;
        end
    end

    // Clip on the unwrapped row coordinate so wrapped rows stay hidden.
    assign y_full = {1'b0, y0_q} + r_e;
    assign vis    = (32'(x_q) < CLIP_W) && (32'(y_full) < CLIP_H);
`else
    assign vis = 1'b1;
`endif

    // Request is captured once; later input changes are ignored until the next IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= '0;
            orient_q <= '0;
            x0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            rows_q   <= '0;
        end else if (load) begin
            mode_q   <= bus_io.mode;
            orient_q <= bus_io.orient;
            x0_q     <= bus_io.x0;
            w_q      <= bus_io.w;
            h_q      <= bus_io.h;
            rows_q   <= rows_in;
        end
    end

    assign bus_io.x       = x_q[CORDW-1:0];
    assign bus_io.y       = y_q;
    assign bus_io.drawing = (state_q == StDraw) && bus_io.oe && vis;
    assign bus_io.busy    = (state_q != StIdle);
    assign bus_io.done    = (state_q == StDone);

endmodule
